// File: rtl/ucsbece154b_gshare_btb_pkg.sv
// Shared constants for the gshare/BTB fetch predictor: counter encodings,
// pipeline opcodes that qualify BranchE/JumpE, and the saturating counter step.
package ucsbece154b_gshare_btb_pkg;

   localparam int PC_W = 32;

   localparam logic [1:0] PHT_SNT = 2'b00;
   localparam logic [1:0] PHT_WNT = 2'b01;
   localparam logic [1:0] PHT_WT  = 2'b10;
   localparam logic [1:0] PHT_ST  = 2'b11;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   function automatic logic [1:0] pht_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      nxt = ctr;
      if (taken) begin
         if (ctr != PHT_ST) nxt = ctr + 2'd1;
      end else begin
         if (ctr != PHT_SNT) nxt = ctr - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/ucsbece154b_btb.sv
// Direct-mapped branch target buffer: combinational lookup, synchronous
// allocate/overwrite, synchronous clear of all valid bits.
module ucsbece154b_btb
   import ucsbece154b_gshare_btb_pkg::*;
#(
   parameter int NUM_ENTRIES = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [PC_W-1:0] rd_pc,
   output logic            rd_hit,
   output logic [PC_W-1:0] rd_target,
   output logic            rd_is_jump,
   input  logic            wr_en,
   input  logic [PC_W-1:0] wr_pc,
   input  logic [PC_W-1:0] wr_target,
   input  logic            wr_is_jump
);

   localparam int IDX_W = $clog2(NUM_ENTRIES);
   localparam int TAG_W = PC_W - 2 - IDX_W;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [PC_W-1:0]  target;
      logic             is_jump;
   } entry_t;

   logic [NUM_ENTRIES-1:0] valid;
   entry_t                 entries [NUM_ENTRIES];

   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] wr_idx;
   logic [TAG_W-1:0] rd_tag;
   entry_t           rd_entry;

   // Instructions are word aligned, so the byte-offset bits never matter.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{rd_pc[1:0], wr_pc[1:0]};

   assign rd_idx   = rd_pc[IDX_W+1:2];
   assign rd_tag   = rd_pc[PC_W-1:IDX_W+2];
   assign wr_idx   = wr_pc[IDX_W+1:2];
   assign rd_entry = entries[rd_idx];

   assign rd_hit     = valid[rd_idx] && (rd_entry.tag == rd_tag);
   assign rd_target  = rd_hit ? rd_entry.target : '0;
   assign rd_is_jump = rd_hit && rd_entry.is_jump;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   // Payload needs no reset; it is only observed behind a set valid bit.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         entries[wr_idx] <= '{tag: wr_pc[PC_W-1:IDX_W+2], target: wr_target, is_jump: wr_is_jump};
      end
   end

endmodule

// File: rtl/ucsbece154b_gshare_btb.sv
// Fetch-stage predictor: gshare direction table (GHR xor PC) combined with a
// direct-mapped BTB; trained non-speculatively from Execute-stage resolution.
module ucsbece154b_gshare_btb
   import ucsbece154b_gshare_btb_pkg::*;
#(
   parameter int NUM_BTB_ENTRIES = 32,
   parameter int NUM_GHR_BITS    = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [31:0]             PCF_i,
   output logic                    BranchTakenF_o,
   output logic [31:0]             BranchTargetF_o,
   output logic [NUM_GHR_BITS-1:0] PHTindexF_o,
   input  logic [31:0]             PCE_i,
   input  logic [31:0]             BranchTargetE_i,
   input  logic [NUM_GHR_BITS-1:0] PHTindexE_i,
   input  logic                    BranchE_i,
   input  logic                    JumpE_i,
   input  logic                    BranchTakenE_i
);

   localparam int PHT_DEPTH = 1 << NUM_GHR_BITS;

   logic [1:0]              pht [PHT_DEPTH];
   logic [NUM_GHR_BITS-1:0] ghr;

   logic btb_hit;
   logic btb_is_jump;
   logic btb_wr_en;
   logic pht_update;

   assign PHTindexF_o = PCF_i[NUM_GHR_BITS+1:2] ^ ghr;

   // Jumps win if the pipeline ever flags both in the same cycle.
   assign pht_update = BranchE_i && !JumpE_i;
   assign btb_wr_en  = JumpE_i || (BranchE_i && BranchTakenE_i);

   ucsbece154b_btb #(
      .NUM_ENTRIES (NUM_BTB_ENTRIES)
   ) u_btb (
      .clk        (clk),
      .reset      (reset),
      .rd_pc      (PCF_i),
      .rd_hit     (btb_hit),
      .rd_target  (BranchTargetF_o),
      .rd_is_jump (btb_is_jump),
      .wr_en      (btb_wr_en),
      .wr_pc      (PCE_i),
      .wr_target  (BranchTargetE_i),
      .wr_is_jump (JumpE_i)
   );

   assign BranchTakenF_o = btb_hit && (btb_is_jump || pht[PHTindexF_o][1]);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PHT_DEPTH; i++) begin
            pht[i] <= PHT_WNT;
         end
         ghr <= '0;
      end else if (pht_update) begin
         pht[PHTindexE_i] <= pht_next(pht[PHTindexE_i], BranchTakenE_i);
         ghr              <= {ghr[NUM_GHR_BITS-2:0], BranchTakenE_i};
      end
   end

endmodule

// File: tb/tb_ucsbece154b_gshare_btb.sv
// Self-checking bench for the gshare/BTB predictor: directed vector table
// followed by randomized traffic against an array-based reference model.
module tb_ucsbece154b_gshare_btb;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PCF_i;
   logic        BranchTakenF_o;
   logic [31:0] BranchTargetF_o;
   logic [4:0]  PHTindexF_o;
   logic [31:0] PCE_i;
   logic [31:0] BranchTargetE_i;
   logic [4:0]  PHTindexE_i;
   logic        BranchE_i;
   logic        JumpE_i;
   logic        BranchTakenE_i;

   int n_tests = 0;
   int n_fail  = 0;

   ucsbece154b_gshare_btb #(
      .NUM_BTB_ENTRIES (32),
      .NUM_GHR_BITS    (5)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .PCF_i           (PCF_i),
      .BranchTakenF_o  (BranchTakenF_o),
      .BranchTargetF_o (BranchTargetF_o),
      .PHTindexF_o     (PHTindexF_o),
      .PCE_i           (PCE_i),
      .BranchTargetE_i (BranchTargetE_i),
      .PHTindexE_i     (PHTindexE_i),
      .BranchE_i       (BranchE_i),
      .JumpE_i         (JumpE_i),
      .BranchTakenE_i  (BranchTakenE_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [31:0] pcf;
      logic [31:0] pce;
      logic [31:0] tgte;
      logic [4:0]  idxe;
      logic        br;
      logic        jmp;
      logic        tkn;
      logic        chk;
      logic        e_tk;
      logic [31:0] e_tgt;
      logic [4:0]  e_idx;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic [31:0] pcf, input logic [31:0] pce,
                      input logic [31:0] tgte, input logic [4:0] idxe, input logic br,
                      input logic jmp, input logic tkn, input logic chk, input logic e_tk,
                      input logic [31:0] e_tgt, input logic [4:0] e_idx);
      vec_t v;
      v = '{rst, pcf, pce, tgte, idxe, br, jmp, tkn, chk, e_tk, e_tgt, e_idx};
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic [31:0] pcf, input logic [31:0] pce,
                        input logic [31:0] tgte, input logic [4:0] idxe, input logic br,
                        input logic jmp, input logic tkn);
      reset           = rst;
      PCF_i           = pcf;
      PCE_i           = pce;
      BranchTargetE_i = tgte;
      PHTindexE_i     = idxe;
      BranchE_i       = br;
      JumpE_i         = jmp;
      BranchTakenE_i  = tkn;
   endtask

   // Reference model: plain arrays indexed by PC arithmetic.
   bit          m_v   [32];
   int unsigned m_tag [32];
   int unsigned m_tgt [32];
   bit          m_j   [32];
   int          m_pht [32];
   int          m_ghr;

   function automatic int bidx(input logic [31:0] pc);
      return int'((pc >> 2) % 32);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_v[i]   = 0;
         m_pht[i] = 1;
      end
      m_ghr = 0;
   endtask

   task automatic model_update(input logic rst, input logic [31:0] pce, input logic [31:0] tgte,
                               input logic [4:0] idxe, input logic br, input logic jmp,
                               input logic tkn);
      int b;
      b = bidx(pce);
      if (rst) begin
         model_reset();
      end else if (jmp) begin
         m_v[b] = 1; m_tag[b] = pce >> 7; m_tgt[b] = tgte; m_j[b] = 1;
      end else if (br) begin
         if (tkn) begin
            m_v[b] = 1; m_tag[b] = pce >> 7; m_tgt[b] = tgte; m_j[b] = 0;
            if (m_pht[idxe] < 3) m_pht[idxe]++;
         end else begin
            if (m_pht[idxe] > 0) m_pht[idxe]--;
         end
         m_ghr = (m_ghr * 2 + (tkn ? 1 : 0)) % 32;
      end
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] pc;
      pc = 32'h0001_0000 + ($urandom_range(0, 3) << 7) + ($urandom_range(0, 31) << 2);
      if ($urandom_range(0, 7) == 0) pc = pc + 32'h0010_0000;
      return pc;
   endfunction

   initial begin
      drive(1'b1, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);

      //  rst  pcf           pce           tgte          idx br jmp tk chk  etk  etgt          eidx
      add(1, 32'h00010000, 32'h0,        32'h0,        0,  0, 0, 0, 0,   0, 32'h0,        0);
      add(0, 32'h00010000, 32'h0,        32'h0,        0,  0, 0, 0, 1,   0, 32'h0,        0);
      add(0, 32'h00010000, 32'h00010010, 32'h00010040, 0,  0, 1, 0, 1,   0, 32'h0,        0);
      add(0, 32'h00010010, 32'h0,        32'h0,        0,  0, 0, 0, 1,   1, 32'h00010040, 4);
      add(0, 32'h00010010, 32'h00010020, 32'h00010100, 8,  1, 0, 1, 1,   1, 32'h00010040, 4);
      add(0, 32'h00010020, 32'h0,        32'h0,        0,  0, 0, 0, 1,   0, 32'h00010100, 9);
      // alias: same index 8, different tag
      add(0, 32'h000100A0, 32'h0,        32'h0,        0,  0, 0, 0, 1,   0, 32'h0,        9);
      add(0, 32'h000100A0, 32'h000100A0, 32'h00010300, 0,  0, 1, 0, 1,   0, 32'h0,        9);
      add(0, 32'h000100A0, 32'h0,        32'h0,        0,  0, 0, 0, 1,   1, 32'h00010300, 9);
      add(0, 32'h00010020, 32'h0,        32'h0,        0,  0, 0, 0, 1,   0, 32'h0,        9);
      // same-cycle update and lookup of 0x00010030
      add(0, 32'h00010030, 32'h00010030, 32'h00010400, 13, 1, 0, 1, 1,   0, 32'h0,        13);
      add(0, 32'h00010030, 32'h0,        32'h0,        0,  0, 0, 0, 1,   0, 32'h00010400, 15);
      // not-taken branches neither invalidate nor allocate
      add(0, 32'h00010030, 32'h000100A0, 32'h0,        0,  1, 0, 0, 1,   0, 32'h00010400, 15);
      add(0, 32'h000100A0, 32'h0,        32'h0,        0,  0, 0, 0, 1,   1, 32'h00010300, 14);
      add(0, 32'h00010040, 32'h00010040, 32'h00010500, 1,  1, 0, 0, 1,   0, 32'h0,        22);
      add(0, 32'h00010040, 32'h0,        32'h0,        0,  0, 0, 0, 1,   0, 32'h0,        28);
      // reset beats a same-cycle taken branch
      add(1, 32'h00010030, 32'h00010050, 32'h00010600, 5,  1, 0, 1, 0,   0, 32'h0,        0);
      add(0, 32'h00010030, 32'h0,        32'h0,        0,  0, 0, 0, 1,   0, 32'h0,        12);
      add(0, 32'h000100A0, 32'h0,        32'h0,        0,  0, 0, 0, 1,   0, 32'h0,        8);
      // allocate indexes 28, 29, 19, 3 as branches (trains PHT[10])
      add(0, 32'h00010000, 32'h00010070, 32'h00020070, 10, 1, 0, 1, 1,   0, 32'h0,        0);
      add(0, 32'h00010000, 32'h00010074, 32'h00020074, 10, 1, 0, 1, 1,   0, 32'h0,        1);
      add(0, 32'h00010000, 32'h0001004C, 32'h0002004C, 10, 1, 0, 1, 1,   0, 32'h0,        3);
      add(0, 32'h00010070, 32'h0001000C, 32'h0002000C, 10, 1, 0, 1, 1,   0, 32'h00020070, 27);
      // saturate PHT[3] upward
      add(0, 32'h00010000, 32'h00010070, 32'h00020070, 3,  1, 0, 1, 1,   0, 32'h0,        15);
      add(0, 32'h00010000, 32'h00010070, 32'h00020070, 3,  1, 0, 1, 1,   0, 32'h0,        31);
      add(0, 32'h00010000, 32'h00010070, 32'h00020070, 3,  1, 0, 1, 1,   0, 32'h0,        31);
      add(0, 32'h00010000, 32'h00010070, 32'h00020070, 3,  1, 0, 1, 1,   0, 32'h0,        31);
      add(0, 32'h00010070, 32'h0,        32'h0,        0,  0, 0, 0, 1,   1, 32'h00020070, 3);
      add(0, 32'h00010070, 32'h00010070, 32'h0,        3,  1, 0, 0, 1,   1, 32'h00020070, 3);
      add(0, 32'h00010074, 32'h0,        32'h0,        0,  0, 0, 0, 1,   1, 32'h00020074, 3);
      // walk PHT[3] down to 00 and hold there
      add(0, 32'h00010000, 32'h00010070, 32'h0,        3,  1, 0, 0, 1,   0, 32'h0,        30);
      add(0, 32'h00010000, 32'h00010070, 32'h0,        3,  1, 0, 0, 1,   0, 32'h0,        28);
      add(0, 32'h00010000, 32'h00010070, 32'h0,        3,  1, 0, 0, 1,   0, 32'h0,        24);
      add(0, 32'h0001004C, 32'h0,        32'h0,        0,  0, 0, 0, 1,   0, 32'h0002004C, 3);
      add(0, 32'h0001004C, 32'h00010070, 32'h0,        3,  1, 0, 0, 1,   0, 32'h0002004C, 3);
      add(0, 32'h0001000C, 32'h0,        32'h0,        0,  0, 0, 0, 1,   0, 32'h0002000C, 3);
      // both strobes: jump wins, PHT/GHR untouched
      add(0, 32'h0001000C, 32'h0001004C, 32'h00020999, 3,  1, 1, 1, 1,   0, 32'h0002000C, 3);
      add(0, 32'h0001004C, 32'h0,        32'h0,        0,  0, 0, 0, 1,   1, 32'h00020999, 19);
      add(0, 32'h0001000C, 32'h0,        32'h0,        0,  0, 0, 0, 1,   0, 32'h0002000C, 3);

      #1;
      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].pcf, vecs[i].pce, vecs[i].tgte, vecs[i].idxe,
               vecs[i].br, vecs[i].jmp, vecs[i].tkn);
         #1;
         if (vecs[i].chk) begin
            check($sformatf("row%0d taken", i), 32'(BranchTakenF_o), 32'(vecs[i].e_tk));
            check($sformatf("row%0d target", i), BranchTargetF_o, vecs[i].e_tgt);
            check($sformatf("row%0d phtidx", i), 32'(PHTindexF_o), 32'(vecs[i].e_idx));
         end
         @(posedge clk);
         #1;
      end

      drive(1'b1, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      model_reset();
      #1;
      for (int c = 0; c < 3000; c++) begin
         logic        rst, br, jmp, tkn, e_hit, e_tk;
         logic [31:0] pcf, pce, tgte, e_tgt;
         logic [4:0]  idxe;
         int          k, b, p;
         rst  = ($urandom_range(0, 199) == 0);
         pcf  = rand_pc();
         pce  = ($urandom_range(0, 1) == 0) ? pcf : rand_pc();
         tgte = $urandom();
         idxe = 5'($urandom_range(0, 31));
         k    = int'($urandom_range(0, 9));
         br   = (k < 4) || (k == 9);
         jmp  = (k == 4) || (k == 5) || ((k == 9) && ($urandom_range(0, 3) == 0));
         tkn  = 1'($urandom_range(0, 1));
         drive(rst, pcf, pce, tgte, idxe, br, jmp, tkn);
         #1;
         if (!rst) begin
            b     = bidx(pcf);
            p     = bidx(pcf) ^ m_ghr;
            e_hit = m_v[b] && (m_tag[b] == (pcf >> 7));
            e_tk  = e_hit && (m_j[b] || (m_pht[p] >= 2));
            e_tgt = e_hit ? m_tgt[b] : 32'h0;
            check($sformatf("rand%0d taken", c), 32'(BranchTakenF_o), 32'(e_tk));
            check($sformatf("rand%0d target", c), BranchTargetF_o, e_tgt);
            check($sformatf("rand%0d phtidx", c), 32'(PHTindexF_o), 32'(p));
         end
         @(posedge clk);
         model_update(rst, pce, tgte, idxe, br, jmp, tkn);
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ucsbece154b_gshare_btb.md
Name: ucsbece154b_gshare_btb

Overview:
Fetch-stage branch predictor that produces the BranchTakenF prediction and predicted target for the pipeline, and absorbs resolved outcomes from Execute. It combines a gshare direction predictor (a global history register XOR PC indexing a table of 2-bit counters, the PHT) with a direct-mapped branch target buffer (BTB). It sits beside the PC mux in the datapath. The perf bench scores its predictions against Execute-stage resolution.

Parameters:
NUM_BTB_ENTRIES, 32, BTB depth; power of two, ≥4.
NUM_GHR_BITS, 5, global history width; PHT depth = 2^NUM_GHR_BITS.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-high.
PCF_i  input  32  fetch PC.
BranchTakenF_o  output  1  predict redirect of PCF_i.
BranchTargetF_o  output  32  predicted target; 0 on BTB miss.
PHTindexF_o  output  NUM_GHR_BITS  PHT index used for this prediction; pipeline carries it to E.
PCE_i  input  32  PC of instruction in Execute.
BranchTargetE_i  input  32  resolved target of instruction in E.
PHTindexE_i  input  NUM_GHR_BITS  PHTindexF_o carried down the pipeline to E.
BranchE_i  input  1  valid conditional branch in E; pipeline gates it with flush/bubble.
JumpE_i  input  1  valid jal/jalr in E; same gating.
BranchTakenE_i  input  1  actual direction of the branch in E.

Behaviour:
- Reset is a decided interface property: one clock; reset synchronous, active-high. Reset wins over any same-cycle update.
- Reset values: all BTB valid bits 0, all PHT counters 2'b01 (weakly not-taken), GHR 0. BranchTakenF_o = 0 and BranchTargetF_o = 0 in the first cycle after reset.
- BTB index = PCF_i[log2(N)+1:2]. Tag = PCF_i[31:log2(N)+2]. Entry fields: valid, tag, target[31:0], is_jump.
- PHTindexF_o = PCF_i[NUM_GHR_BITS+1:2] XOR GHR.
- Prediction is combinational from PCF_i and registered state, with zero cycle latency. hit = valid && tag match.
- BranchTakenF_o = hit && (is_jump || PHT[PHTindexF_o][1]).
- BranchTargetF_o = hit ? target : 0.
- Update on posedge when BranchE_i or JumpE_i is 1. BranchE_i and JumpE_i are never both 1; if they are, JumpE_i takes priority.
- JumpE_i: write the BTB entry at the PCE_i index with valid=1, tag, target=BranchTargetE_i, is_jump=1. PHT and GHR are unchanged. A jalr target is overwritten on each execution.
- BranchE_i, taken: write the BTB entry with is_jump=0. PHT[PHTindexE_i] increments, saturating at 11. GHR <= {GHR[G-2:0],1}.
- BranchE_i, not taken: BTB unchanged (no allocation, no invalidation). PHT[PHTindexE_i] decrements, saturating at 00. GHR <= {GHR[G-2:0],0}.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- GHR is updated non-speculatively at resolution only. The F-to-E index skew is accepted; PHT updates always use PHTindexE_i, never a recomputed index.
- Same-cycle lookup and update to the same BTB or PHT entry: lookup returns the old value (no bypass). The new value is visible the next cycle.
- Aliasing: a different tag at the same BTB index is a miss; allocation overwrites the old entry.
- Reset mid-operation: all state returns to reset values on that edge regardless of pending updates.
- No stall input: the pipeline presents BranchE_i/JumpE_i for exactly one cycle per resolved instruction.

Decomposition:
- Shared define/include file holds the counter encodings (SNT/WNT/WT/ST) and the opcode constants the pipeline uses to derive BranchE/JumpE (1100011, 1101111, 1100111).
- One sub-module: ucsbece154b_btb, holding the direct-mapped array with combinational read and synchronous write/clear.
- PHT and GHR stay in the top of this block.

Test Plan:
1. Reset, then PCF_i=0x00010000 -> BranchTakenF_o=0, BranchTargetF_o=0, PHTindexF_o=0x00.
2. JumpE_i=1, PCE_i=0x00010010, BranchTargetE_i=0x00010040; next cycle PCF_i=0x00010010 -> BranchTakenF_o=1, BranchTargetF_o=0x00010040. GHR stays 0.
3. Branch at 0x00010020 (index 0x08): BranchE_i=1, taken, PHTindexE_i=0x08 -> PHT[8] 01->10, GHR=00001. Then PCF_i=0x00010020 -> PHTindexF_o=0x09; PHT[9]=01 -> BranchTakenF_o=0 although BTB hits.
4. Saturation: four taken updates at index 3 -> 11; one not-taken -> 10, still predicts taken; three not-taken -> 00, further not-taken stays 00.
5. Alias: allocate 0x00010020, then look up 0x000100A0 (same index, different tag) -> miss. Allocate 0x000100A0 -> 0x00010020 now misses.
6. Same-cycle update and lookup of 0x00010030 -> old (miss) this cycle, hit next cycle. Assert reset with BranchE_i=1 -> all entries invalid, PHT=01, GHR=0.
